// File: rtl/keccak_absorb_padder_pkg.sv
// rtl/keccak_absorb_padder_pkg.sv - Keccak mode table, absorb FSM states and rate/suffix helpers
package keccak_absorb_padder_pkg;

  localparam int DWIDTH         = 256;
  localparam int KEEP_WIDTH     = DWIDTH / 8;
  localparam int RATE_MAX_BYTES = 168;
  localparam int RATE_WIDTH     = 8;
  localparam int MODE_SEL_WIDTH = 2;

  localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

  typedef enum logic [MODE_SEL_WIDTH-1:0] {
    SHA3_256 = 2'd0,
    SHA3_512 = 2'd1,
    SHAKE128 = 2'd2,
    SHAKE256 = 2'd3
  } keccak_mode_t;

  typedef enum logic [1:0] {
    ABS_IDLE,
    ABS_ABSORB,
    ABS_PAD,
    ABS_EMIT
  } absorb_state_t;

  function automatic logic [RATE_WIDTH-1:0] mode_rate_bytes(keccak_mode_t mode);
    case (mode)
      SHA3_256: mode_rate_bytes = 8'd136;
      SHA3_512: mode_rate_bytes = 8'd72;
      SHAKE128: mode_rate_bytes = 8'd168;
      default:  mode_rate_bytes = 8'd136;
    endcase
  endfunction

  function automatic logic [7:0] mode_suffix(keccak_mode_t mode);
    mode_suffix = (mode == SHAKE128 || mode == SHAKE256) ? SUFFIX_SHAKE : SUFFIX_SHA3;
  endfunction

endpackage

// File: rtl/keccak_absorb_padder.sv
// rtl/keccak_absorb_padder.sv - packs byte-keep beats into rate blocks and applies suffix + pad10*1
module keccak_absorb_padder
  import keccak_absorb_padder_pkg::*;
#(
  parameter int DWIDTH     = keccak_absorb_padder_pkg::DWIDTH,
  parameter int KEEP_WIDTH = keccak_absorb_padder_pkg::KEEP_WIDTH,
  parameter int RATE_MAX   = RATE_MAX_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] mode_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [DWIDTH-1:0]         s_data_i,
  input  logic [KEEP_WIDTH-1:0]     s_keep_i,
  input  logic                      s_last_i,
  output logic                      blk_valid_o,
  input  logic                      blk_ready_i,
  output logic [RATE_MAX*8-1:0]     blk_data_o,
  output logic [RATE_WIDTH-1:0]     blk_rate_o,
  output logic                      blk_last_o,
  output logic                      busy_o
);

  localparam int BUF_W = RATE_MAX * 8;
  localparam int CNT_W = $clog2(KEEP_WIDTH + 1);

  absorb_state_t         state_q, state_d;
  keccak_mode_t          mode_q, mode_d;
  logic [RATE_WIDTH-1:0] offset_q, offset_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [DWIDTH-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                  hold_last_q, hold_last_d;
  logic                  pad_pend_q, pad_pend_d;
  logic                  last_q, last_d;

  logic [RATE_WIDTH-1:0] rate, rate_m1, room, fill_end;
  logic [7:0]            suffix;
  logic [CNT_W-1:0]      take, keep_cnt;
  logic [BUF_W-1:0]      hold_ext, fill_buf, pad_buf;

  assign rate     = mode_rate_bytes(mode_q);
  assign rate_m1  = rate - 1'b1;
  assign suffix   = mode_suffix(mode_q);
  assign room     = rate - offset_q;
  assign take     = (RATE_WIDTH'(hold_cnt_q) <= room) ? hold_cnt_q : room[CNT_W-1:0];
  assign fill_end = offset_q + RATE_WIDTH'(take);
  // Hold bytes pre-aligned to the write offset so each lane needs only a range compare.
  assign hold_ext = BUF_W'(hold_q) << {offset_q, 3'b000};

  for (genvar i = 0; i < RATE_MAX; i++) begin : g_lane
    localparam logic [RATE_WIDTH-1:0] IDX = RATE_WIDTH'(i);
    assign fill_buf[8*i +: 8] = (offset_q <= IDX && IDX < fill_end) ? hold_ext[8*i +: 8]
                                                                   : buf_q[8*i +: 8];
    assign pad_buf[8*i +: 8]  = buf_q[8*i +: 8]
                              ^ ((IDX == offset_q) ? suffix : 8'h00)
                              ^ ((IDX == rate_m1)  ? 8'h80  : 8'h00);
  end

  assign s_ready_o   = (state_q == ABS_ABSORB) && (hold_cnt_q == '0) && !pad_pend_q && !hold_last_q;
  assign blk_valid_o = (state_q == ABS_EMIT);
  assign blk_data_o  = buf_q;
  assign blk_rate_o  = rate;
  assign blk_last_o  = blk_valid_o && last_q;
  assign busy_o      = (state_q != ABS_IDLE);

  always_comb begin
    keep_cnt = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      keep_cnt = keep_cnt + CNT_W'(s_keep_i[k]);
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    offset_d    = offset_q;
    buf_d       = buf_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    hold_last_d = hold_last_q;
    pad_pend_d  = pad_pend_q;
    last_d      = last_q;
    case (state_q)
      ABS_IDLE: begin
        if (start_i) begin
          mode_d      = keccak_mode_t'(mode_i);
          offset_d    = '0;
          buf_d       = '0;
          hold_cnt_d  = '0;
          hold_last_d = 1'b0;
          pad_pend_d  = 1'b0;
          state_d     = ABS_ABSORB;
        end
      end
      ABS_ABSORB: begin
        if (hold_cnt_q != '0) begin
          buf_d      = fill_buf;
          hold_d     = hold_q >> {take, 3'b000};
          hold_cnt_d = hold_cnt_q - take;
          offset_d   = fill_end;
          if (fill_end == rate) begin
            state_d = ABS_EMIT;
            last_d  = 1'b0;
            // Message ended exactly on a block boundary: padding needs a block of its own.
            if (hold_cnt_d == '0 && hold_last_q) begin
              pad_pend_d  = 1'b1;
              hold_last_d = 1'b0;
            end
          end
        end else if (hold_last_q || pad_pend_q) begin
          hold_last_d = 1'b0;
          pad_pend_d  = 1'b0;
          state_d     = ABS_PAD;
        end else if (s_valid_i && s_ready_o) begin
          hold_d      = s_data_i;
          hold_cnt_d  = keep_cnt;
          hold_last_d = s_last_i;
        end
      end
      ABS_PAD: begin
        buf_d   = pad_buf;
        last_d  = 1'b1;
        state_d = ABS_EMIT;
      end
      ABS_EMIT: begin
        if (blk_ready_i) begin
          buf_d    = '0;
          offset_d = '0;
          last_d   = 1'b0;
          state_d  = last_q ? ABS_IDLE : ABS_ABSORB;
        end
      end
      default: state_d = ABS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ABS_IDLE;
      mode_q      <= SHA3_256;
      offset_q    <= '0;
      buf_q       <= '0;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      hold_last_q <= 1'b0;
      pad_pend_q  <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      offset_q    <= offset_d;
      buf_q       <= buf_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_last_q <= hold_last_d;
      pad_pend_q  <= pad_pend_d;
      last_q      <= last_d;
    end
  end

endmodule
